// File: rtl/sim_fifo512_pkg.sv
// sim_fifo512_pkg: default geometry shared by the 512 x 8 transmit FIFO and its RAM.
package sim_fifo512_pkg;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_DEPTH  = 512;
    localparam int DEF_ADDR_W = $clog2(DEF_DEPTH);
endpackage

// File: rtl/fifo_ram.sv
// fifo_ram: simple dual-port RAM, synchronous write, registered read with enable.
module fifo_ram
    import sim_fifo512_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] q
);
    logic [DATA_W-1:0] mem [DEPTH];
    // array stays unreset so it maps onto block RAM; only the output register clears
    always_ff @(posedge clock) begin
        if (we) mem[waddr] <= wdata;
    end
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) q <= '0;
        else if (re) q <= mem[raddr];
    end
endmodule

// File: rtl/sim_fifo512.sv
// sim_fifo512: single-clock 512 x 8 FIFO, registered q (no show-ahead).
// Define FIFO_USEDW_EN to expose the occupancy count on usedw.
module sim_fifo512
    import sim_fifo512_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = DEF_ADDR_W
) (
`ifdef FIFO_USEDW_EN
    output logic [ADDR_W:0]   usedw,
`endif
    input  logic              clock,
    input  logic              rst,
    input  logic [DATA_W-1:0] data,
    input  logic              wrreq,
    input  logic              rdreq,
    output logic [DATA_W-1:0] q,
    output logic              full,
    output logic              empty
);
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic [ADDR_W:0]   count;
    logic              wr_ok, rd_ok;
    assign full  = count == (ADDR_W+1)'(DEPTH);
    assign empty = count == '0;
    assign wr_ok = wrreq & ~full;
    assign rd_ok = rdreq & ~empty;
`ifdef FIFO_USEDW_EN
    assign usedw = count;
`endif
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
            if (wr_ok != rd_ok) count <= wr_ok ? count + 1'b1 : count - 1'b1;
        end
    end
    fifo_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ram (
        .clock(clock),
        .rst  (rst),
        .we   (wr_ok),
        .waddr(wr_ptr),
        .wdata(data),
        .re   (rd_ok),
        .raddr(rd_ptr),
        .q    (q)
    );
endmodule

// File: tb/tb_sim_fifo512.sv
// tb_sim_fifo512: directed vector table plus hand sequences for reset, fill, simultaneous access and wrap.
module tb_sim_fifo512;
    import sim_fifo512_pkg::*;
    logic clock = 1'b0, rst = 1'b0, wrreq = 1'b0, rdreq = 1'b0;
    logic [DEF_DATA_W-1:0] data = '0;
    logic [DEF_DATA_W-1:0] q;
    logic full, empty;
`ifdef FIFO_USEDW_EN
    logic [DEF_ADDR_W:0] usedw;
`endif
    int errors = 0, checks = 0;
    logic [7:0] mq [$];
    logic [7:0] exp_q = 8'h00;

    typedef struct {
        logic       w;
        logic       r;
        logic [7:0] d;
        logic [7:0] eq;
        logic       ee;
        logic       ef;
    } vec_t;
    vec_t tbl [10];

    always #5 clock = ~clock;

    sim_fifo512 dut (
`ifdef FIFO_USEDW_EN
        .usedw(usedw),
`endif
        .clock(clock),
        .rst  (rst),
        .data (data),
        .wrreq(wrreq),
        .rdreq(rdreq),
        .q    (q),
        .full (full),
        .empty(empty)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // one clock with the given request pattern, checked against a queue model of the FIFO
    task automatic cyc(input logic w, input logic r, input logic [7:0] d);
        bit wa, ra;
        wrreq = w;
        rdreq = r;
        data  = d;
        wa = w && mq.size() < 512;
        ra = r && mq.size() > 0;
        @(posedge clock);
        #1;
        if (ra) exp_q = mq.pop_front();
        if (wa) mq.push_back(d);
        wrreq = 1'b0;
        rdreq = 1'b0;
        chk("q", q, exp_q);
        chk("empty", empty, mq.size() == 0);
        chk("full", full, mq.size() == 512);
`ifdef FIFO_USEDW_EN
        chk("usedw", usedw, mq.size());
`endif
    endtask

    initial begin
        int written, guard;
        tbl[0] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 8'h41, 8'h00, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 1'b1, 8'h00, 8'h41, 1'b1, 1'b0};
        tbl[3] = '{1'b0, 1'b1, 8'h00, 8'h41, 1'b1, 1'b0};
        tbl[4] = '{1'b1, 1'b1, 8'h10, 8'h41, 1'b0, 1'b0};
        tbl[5] = '{1'b1, 1'b0, 8'h11, 8'h41, 1'b0, 1'b0};
        tbl[6] = '{1'b1, 1'b1, 8'h12, 8'h10, 1'b0, 1'b0};
        tbl[7] = '{1'b0, 1'b1, 8'h00, 8'h11, 1'b0, 1'b0};
        tbl[8] = '{1'b0, 1'b1, 8'h00, 8'h12, 1'b1, 1'b0};
        tbl[9] = '{1'b0, 1'b0, 8'h00, 8'h12, 1'b1, 1'b0};

        #12;
        chk("reset_q", q, 8'h00);
        chk("reset_empty", empty, 1'b1);
        chk("reset_full", full, 1'b0);
        rst = 1'b1;
        @(posedge clock);
        #1;
        for (int i = 0; i < 10; i++) begin
            wrreq = tbl[i].w;
            rdreq = tbl[i].r;
            data  = tbl[i].d;
            @(posedge clock);
            #1;
            chk($sformatf("vec%0d_q", i), q, tbl[i].eq);
            chk($sformatf("vec%0d_empty", i), empty, tbl[i].ee);
            chk($sformatf("vec%0d_full", i), full, tbl[i].ef);
        end
        wrreq = 1'b0;
        rdreq = 1'b0;
        mq.delete();
        exp_q = tbl[9].eq;

        // asynchronous reset in the middle of a write burst
        cyc(1'b1, 1'b0, 8'h21);
        cyc(1'b1, 1'b0, 8'h22);
        cyc(1'b0, 1'b1, 8'h00);
        wrreq = 1'b1;
        data  = 8'h23;
        #2 rst = 1'b0;
        #1;
        chk("midrst_empty", empty, 1'b1);
        chk("midrst_full", full, 1'b0);
        chk("midrst_q", q, 8'h00);
        wrreq = 1'b0;
        #1 rst = 1'b1;
        mq.delete();
        exp_q = 8'h00;
        cyc(1'b0, 1'b1, 8'h00);
        chk("postrst_q", q, 8'h00);

        // fill to 512, overflow attempt, drain in order
        for (int i = 0; i < 512; i++) begin
            cyc(1'b1, 1'b0, 8'(i));
            if (i == 510) chk("fill_not_full_511", full, 1'b0);
        end
        chk("fill_full", full, 1'b1);
        cyc(1'b1, 1'b0, 8'hAA);
        chk("overflow_full", full, 1'b1);
        for (int i = 0; i < 512; i++) begin
            cyc(1'b0, 1'b1, 8'h00);
            chk("drain_order", q, i % 256);
        end
        chk("drain_empty", empty, 1'b1);
        cyc(1'b0, 1'b1, 8'h00);
        chk("underflow_q", q, 8'hFF);

        // write+read together at count 3, then at empty
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 8'hA0 + 8'(i));
        for (int i = 0; i < 10; i++) cyc(1'b1, 1'b1, 8'hB0 + 8'(i));
        chk("simul_count3", mq.size(), 3);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b1, 8'h00);
            chk("simul_order", q, 8'hB7 + 8'(i));
        end
        cyc(1'b1, 1'b1, 8'h5C);
        chk("empty_simul_q", q, 8'hB9);
        chk("empty_simul_empty", empty, 1'b0);
        cyc(1'b0, 1'b1, 8'h00);
        chk("empty_simul_data", q, 8'h5C);

        // long stream with wrapping pointers, occupancy kept between 1 and 100
        written = 0;
        guard = 0;
        while (written < 1500 && guard < 20000) begin
            bit w, r;
            w = mq.size() < 100 && (mq.size() < 2 || $urandom_range(0, 2) != 0);
            r = mq.size() > 1 && $urandom_range(0, 1) == 1;
            cyc(w, r, 8'(written) ^ 8'h5A);
            if (w) written++;
            guard++;
        end
        while (mq.size() > 0 && guard < 20000) begin
            cyc(1'b0, 1'b1, 8'h00);
            guard++;
        end
        chk("wrap_done", guard < 20000, 1'b1);
        chk("wrap_empty", empty, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
